// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU field widths, special encodings, field helpers and FSM states
package fpu_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS = 127;
    localparam int FP_W = 1 + EXP_W + MAN_W;
    localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;
    localparam logic [FP_W-1:0] PINF = 32'h7F80_0000;
    typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;
    function automatic logic [EXP_W-1:0] fp_exp(input logic [FP_W-1:0] w);
        return w[MAN_W +: EXP_W];
    endfunction
    function automatic logic [MAN_W-1:0] fp_man(input logic [FP_W-1:0] w);
        return w[MAN_W-1:0];
    endfunction
endpackage

// File: rtl/fixed_mul_iter.sv
// fixed_mul_iter: unsigned radix-2 shift-add multiplier, one multiplier bit per cycle
// Ports: clk, reset (sync, active-high), start (taken when idle), a/b operands,
//        busy (accumulating), valid (final accumulate this cycle; prod is complete
//        now and holds until the next start), prod = a*b.
module fixed_mul_iter #(
    parameter int WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 valid,
    output logic [2*WIDTH-1:0]   prod
);
    localparam int IW = $clog2(WIDTH);
    logic [WIDTH-1:0] a_q, b_q;
    logic [2*WIDTH-1:0] acc, addend;
    logic [IW-1:0] idx;
    // prod includes the current step's addend so the full product is visible during valid
    assign addend = (busy && b_q[idx]) ? {{WIDTH{1'b0}}, a_q} << idx : '0;
    assign prod = acc + addend;
    assign valid = busy && idx == IW'(WIDTH - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            idx <= '0;
            acc <= '0;
            a_q <= '0;
            b_q <= '0;
        end else if (!busy) begin
            if (start) begin
                a_q <= a;
                b_q <= b;
                acc <= '0;
                idx <= '0;
                busy <= 1'b1;
            end
        end else begin
            acc <= prod;
            idx <= valid ? '0 : idx + 1'b1;
            if (valid) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/fp_square.sv
// fp_square: iterative IEEE-754 single-precision squarer, result = x*x
// Ports: clk, reset (sync, active-high), start (taken only in IDLE), dataIn (operand x),
//        busy (operation in flight), valid (one-cycle pulse, result updated),
//        result (x*x, sign always 0, held until the next valid).
// Latency: start at edge k -> busy k+1..k+25, valid at k+26, for every input.
// Build option: define FP_SQUARE_RNE_EN for round-to-nearest-even; default truncates.
module fp_square
    import fpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [FP_W-1:0]   dataIn,
    output logic              busy,
    output logic              valid,
    output logic [FP_W-1:0]   result
);
    localparam int EW = EXP_W + 2;
    state_t state;
    logic [FP_W-2:0] x;
    logic [EXP_W-1:0] ex;
    logic [MAN_W-1:0] mx, m_t, man;
    logic [2*MAN_W+1:0] p;
    logic hi, mul_busy, mul_valid, ovf, unf;
    logic signed [EW-1:0] e_t, e;
    logic [FP_W-1:0] res;
    fixed_mul_iter #(.WIDTH(MAN_W + 1)) u_mul (
        .clk(clk),
        .reset(reset),
        .start(state == IDLE && start && !mul_busy),
        .a({1'b1, fp_man(dataIn)}),
        .b({1'b1, fp_man(dataIn)}),
        .busy(mul_busy),
        .valid(mul_valid),
        .prod(p)
    );
    assign ex = fp_exp({1'b0, x});
    assign mx = fp_man({1'b0, x});
    // product of two [1,2) mantissas lies in [1,4); the top bit selects the normalisation shift
    assign hi = p[2*MAN_W+1];
    assign m_t = hi ? p[2*MAN_W:MAN_W+1] : p[2*MAN_W-1:MAN_W];
    assign e_t = EW'({ex, 1'b0}) - EW'(BIAS) + EW'(hi);
`ifdef FP_SQUARE_RNE_EN
    logic g, s, unused_sign;
    logic [MAN_W:0] m_r;
    assign g = hi ? p[MAN_W] : p[MAN_W-1];
    assign s = hi ? |p[MAN_W-1:0] : |p[MAN_W-2:0];
    assign m_r = {1'b0, m_t} + (MAN_W + 1)'(g & (s | m_t[0]));
    // a carry out leaves the mantissa field all zeros, i.e. 1.0 at the next exponent
    assign man = m_r[MAN_W-1:0];
    assign e = e_t + EW'(m_r[MAN_W]);
    assign unused_sign = dataIn[FP_W-1];
`else
    logic [MAN_W:0] unused_low;
    assign man = m_t;
    assign e = e_t;
    assign unused_low = {dataIn[FP_W-1], p[MAN_W-1:0]};
`endif
    assign ovf = !e[EW-1] && e[EW-2:0] >= (EW - 1)'((1 << EXP_W) - 1);
    assign unf = e[EW-1] || e == '0;
    assign res = ex == '0 ? '0 :
                 ex == '1 ? (mx != '0 ? QNAN : PINF) :
                 ovf ? PINF :
                 unf ? '0 : {1'b0, e[EXP_W-1:0], man};
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy <= 1'b0;
            valid <= 1'b0;
            result <= '0;
            x <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    x <= dataIn[FP_W-2:0];
                    busy <= 1'b1;
                    state <= CALC;
                end
                CALC: if (mul_valid) state <= NORM;
                NORM: begin
                    result <= res;
                    valid <= 1'b1;
                    busy <= 1'b0;
                    state <= DONE;
                end
                DONE: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_square.sv
// tb_fp_square: directed self-checking bench for fp_square
module tb_fp_square;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [31:0] dataIn = '0;
    logic busy, valid;
    logic [31:0] result;
    int total = 0;
    int bad = 0;

    fp_square dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .dataIn(dataIn),
        .busy(busy),
        .valid(valid),
        .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // cyc is the cycle index (relative to the accepting edge k) at which valid was seen
    task automatic do_op(input logic [31:0] xin, output logic [31:0] r, output int cyc);
        start = 1'b1;
        dataIn = xin;
        step();
        start = 1'b0;
        cyc = 1;
        while (valid !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        r = result;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++;
        if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        total++;
        if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 00000000", result); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_latency();
        start = 1'b1;
        dataIn = 32'h4000_0000;
        step();
        start = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            total++;
            if (busy !== 1'b1 || valid !== 1'b0) begin
                bad++;
                $display("FAIL latency_window k+%0d: busy=%b valid=%b want busy=1 valid=0", c, busy, valid);
            end
            step();
        end
        total++;
        if (valid !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL latency_done k+26: busy=%b valid=%b want busy=0 valid=1", busy, valid);
        end
        total++;
        if (result !== 32'h4080_0000) begin bad++; $display("FAIL latency_result: got %h want 40800000", result); end
        step();
        total++;
        if (valid !== 1'b0 || result !== 32'h4080_0000) begin
            bad++;
            $display("FAIL valid_pulse_hold: valid=%b result=%h want valid=0 result=40800000", valid, result);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] vin [13];
        logic [31:0] vexp [13];
        logic [31:0] r;
        int cyc;
        vin[0] = 32'h3FC0_0000;  vexp[0] = 32'h4010_0000;
        vin[1] = 32'hC040_0000;  vexp[1] = 32'h4110_0000;
        vin[2] = 32'h60AD_78EC;  vexp[2] = 32'h7F80_0000;
        vin[3] = 32'h1F00_0000;  vexp[3] = 32'h0000_0000;
        vin[4] = 32'h0000_0001;  vexp[4] = 32'h0000_0000;
        vin[5] = 32'h7F80_0000;  vexp[5] = 32'h7F80_0000;
        vin[6] = 32'hFFC0_0001;  vexp[6] = 32'h7FC0_0000;
        vin[7] = 32'h0000_0000;  vexp[7] = 32'h0000_0000;
        vin[8] = 32'h7F80_0001;  vexp[8] = 32'h7FC0_0000;
        vin[9] = 32'h5F80_0000;  vexp[9] = 32'h7F80_0000;
        vin[10] = 32'h5F7F_FFFF; vexp[10] = 32'h7F7F_FFFE;
        vin[11] = 32'h2000_0000; vexp[11] = 32'h0080_0000;
        vin[12] = 32'h3F80_0801;
`ifdef FP_SQUARE_RNE_EN
        vexp[12] = 32'h3F80_1003;
`else
        vexp[12] = 32'h3F80_1002;
`endif
        for (int i = 0; i < 13; i++) begin
            do_op(vin[i], r, cyc);
            total++;
            if (r !== vexp[i]) begin
                bad++;
                $display("FAIL vec%0d x=%h: result=%h want %h", i, vin[i], r, vexp[i]);
            end
            total++;
            if (cyc != 26) begin
                bad++;
                $display("FAIL vec%0d_latency x=%h: valid at k+%0d want k+26", i, vin[i], cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        int cyc;
        do_op(32'h4000_0000, r, cyc);
        do_op(32'hC040_0000, r, cyc);
        total++;
        if (r !== 32'h4110_0000 || cyc != 26) begin
            bad++;
            $display("FAIL back_to_back: result=%h at k+%0d want 41100000 at k+26", r, cyc);
        end
    endtask

    task automatic test_start_in_done();
        int cyc;
        start = 1'b1;
        dataIn = 32'h3FC0_0000;
        step();
        start = 1'b0;
        cyc = 1;
        while (valid !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        start = 1'b1;
        dataIn = 32'h4000_0000;
        step();
        start = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL start_in_done: busy=%b want 0", busy); end
        step();
        total++;
        if (busy !== 1'b0 || result !== 32'h4010_0000) begin
            bad++;
            $display("FAIL start_in_done_idle: busy=%b result=%h want busy=0 result=40100000", busy, result);
        end
    endtask

    task automatic test_ignore_busy();
        int nvalid, first;
        logic [31:0] r;
        start = 1'b1;
        dataIn = 32'h3FC0_0000;
        step();
        start = 1'b0;
        for (int c = 2; c <= 5; c++) step();
        start = 1'b1;
        dataIn = 32'hC040_0000;
        step();
        start = 1'b0;
        nvalid = 0;
        first = 0;
        r = '0;
        for (int c = 6; c <= 60; c++) begin
            if (valid === 1'b1) begin
                if (nvalid == 0) begin first = c; r = result; end
                nvalid++;
            end
            step();
        end
        total++;
        if (nvalid != 1 || first != 26) begin
            bad++;
            $display("FAIL ignore_busy_pulses: %0d valid pulses first at k+%0d want 1 at k+26", nvalid, first);
        end
        total++;
        if (r !== 32'h4010_0000) begin bad++; $display("FAIL ignore_busy_result: got %h want 40100000", r); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] r;
        int cyc;
        start = 1'b1;
        dataIn = 32'h4040_0000;
        step();
        start = 1'b0;
        for (int c = 2; c <= 9; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_flags: busy=%b valid=%b want 0 0", busy, valid);
        end
        total++;
        if (result !== 32'h0) begin bad++; $display("FAIL abort_result: got %h want 00000000", result); end
        step();
        total++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: busy=%b valid=%b want 0 0", busy, valid);
        end
        do_op(32'h3FC0_0000, r, cyc);
        total++;
        if (r !== 32'h4010_0000 || cyc != 26) begin
            bad++;
            $display("FAIL after_abort: result=%h at k+%0d want 40100000 at k+26", r, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_back_to_back();
        test_start_in_done();
        test_ignore_busy();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
